mem_word_sequencer: RTL and testbench
=====================================

Name: mem_word_sequencer

Overview:
- Sits between the multicycle core datapath and the 8-bit external memory (256 x 8, registered read, synchronous write on posedge clk).
- Turns one multi-byte word request (read or write) into a sequence of single-byte memory accesses at consecutive addresses.
- Assembles read bytes into a word (little-endian) and returns it with a one-cycle done pulse.

Parameters:
- NBYTES, 4, bytes per word access (legal 1..4); word width is 8*NBYTES.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- req  in  1  start request; sampled only when idle
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  8  base byte address; sampled with req
- wdata  in  8*NBYTES  write word; sampled with req
- rdata  out  8*NBYTES  last completed read word
- done  out  1  one-cycle completion pulse
- busy  out  1  high while an access is in progress
- memread  out  1  byte read strobe to memory
- memwrite  out  1  byte write strobe to memory
- adr  out  8  byte address to memory
- writedata  out  8  byte write data to memory
- memdata  in  8  registered read byte from memory (valid the cycle after memread/adr)

Behaviour:
- States: IDLE, RD, RTAIL, WR. Registers: state, cnt (byte index), base, we_r, wdata_r, rdata, done.
- Reset: state=IDLE, cnt=0, rdata=0, done=0. busy=0, memread=0, memwrite=0, adr=0, writedata=0 in the cycle after the reset edge.
- IDLE: on edge E0 with req=1, latch addr/we/wdata, set cnt=0, go to RD (we=0) or WR (we=1). req=0 means stay in IDLE.
- Memory-side outputs are combinational from registered state only:
  - adr = base+cnt, mod 256 (wraps 0xFF->0x00).
  - memread = (state==RD).
  - memwrite = (state==WR).
  - writedata = wdata_r[8*cnt+7 : 8*cnt] in WR, else 0.
  - adr = 0 in IDLE/RTAIL.
  - memread and memwrite are never both high.
- RD:
  - Each edge increments cnt.
  - When cnt>=1, capture memdata into byte lane cnt-1 of a shift/assembly register.
  - On the edge where cnt==NBYTES-1, go to RTAIL.
- RTAIL: no strobes. On the next edge, capture memdata into lane NBYTES-1, load rdata with the assembled word, pulse done, go to IDLE.
- WR: each edge writes one byte (memory commits it) and increments cnt. On the edge where cnt==NBYTES-1, pulse done and go to IDLE.
- Latency, counted from request edge E0:
  - Read: done high in the cycle after edge E0+NBYTES+1 (NBYTES=4: 5 edges).
  - Write: done high in the cycle after edge E0+NBYTES.
- Byte order is little-endian: byte at base+k goes to bits [8k+7:8k], for both read and write.
- done is high for exactly one cycle. A request may be accepted on the edge that ends the done cycle (back-to-back, zero idle gap).
- busy = (state!=IDLE). req/we/addr/wdata are ignored while busy; a held req starts a new access once IDLE.
- rdata holds until the next read completes; writes never modify rdata. Partial read data is never visible on rdata.
- Reset mid-operation aborts immediately:
  - No strobes in the cycle after the reset edge; no done pulse.
  - Bytes already written stay written.
  - rdata=0.
- addr has no alignment requirement.

Test Plan:
- Read: preload mem[0x10..0x13]=78,56,34,12; req, we=0, addr=0x10.
  - memread high 4 cycles with adr 10,11,12,13.
  - rdata=0x12345678, done one cycle 5 edges after acceptance, busy low after.
- Write then read: write wdata=0xDEADBEEF at 0x20.
  - mem[0x20..0x23]=EF,BE,AD,DE; done 4 edges after acceptance; rdata unchanged.
  - Read back of 0x20 gives 0xDEADBEEF.
- Wrap: preload mem[FE,FF,00,01]=01,02,03,04; read at 0xFE.
  - adr sequence FE,FF,00,01; rdata=0x04030201.
- Busy/back-to-back:
  - Pulse req with addr=0x30 while a read is busy: ignored, no extra strobes.
  - Hold req high through done: second access begins on the edge ending done, with no gap.
- Reset mid-write: write 0x11223344 at 0x40, assert reset after 2 bytes are written.
  - mem[0x40]=44, mem[0x41]=33, mem[0x42..0x43] unchanged.
  - No done; all outputs 0 the next cycle.
- NBYTES=1: read of 0x05 holding 0xA5 -> rdata=0xA5, done 2 edges after acceptance; write -> done after 1 edge.

Source files
------------

// File: rtl/mem_word_sequencer.sv
// Breaks one multi-byte word read/write into consecutive single-byte accesses
// on an 8-bit registered-read memory; read bytes assemble little-endian.
module mem_word_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [7:0]            addr,
  input  logic [8*NBYTES-1:0]   wdata,
  output logic [8*NBYTES-1:0]   rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  memread,
  output logic                  memwrite,
  output logic [7:0]            adr,
  output logic [7:0]            writedata,
  input  logic [7:0]            memdata
);

  localparam int W = 8 * NBYTES;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] RTAIL = 2'd2;
  localparam logic [1:0] WR    = 2'd3;

  localparam logic [1:0] LAST = 2'(NBYTES - 1);

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [7:0]   base;
  logic [W-1:0] wdata_r;
  logic [W-1:0] asm_r;
  logic [W-1:0] rword;

  assign busy     = (state != IDLE);
  assign memread  = (state == RD);
  assign memwrite = (state == WR);

  // Address only driven while a strobe is active; wraps naturally at 8 bits.
  always_comb begin
    adr = 8'h00;
    if (state == RD || state == WR)
      adr = base + {6'b000000, cnt};
  end

  always_comb begin
    writedata = 8'h00;
    for (int i = 0; i < NBYTES; i++)
      if (state == WR && cnt == 2'(i))
        writedata = wdata_r[8*i +: 8];
  end

  // The last byte arrives in RTAIL and is merged directly into the result.
  always_comb begin
    rword = asm_r;
    rword[8*(NBYTES-1) +: 8] = memdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      base    <= 8'h00;
      wdata_r <= '0;
      asm_r   <= '0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            base    <= addr;
            wdata_r <= wdata;
            cnt     <= 2'd0;
            state   <= we ? WR : RD;
          end
        end
        RD: begin
          // memdata lags the strobe by one cycle, so it belongs to lane cnt-1.
          for (int i = 0; i < NBYTES - 1; i++)
            if (cnt == 2'(i + 1))
              asm_r[8*i +: 8] <= memdata;
          if (cnt == LAST) begin
            cnt   <= 2'd0;
            state <= RTAIL;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RTAIL: begin
          rdata <= rword;
          done  <= 1'b1;
          cnt   <= 2'd0;
          state <= IDLE;
        end
        WR: begin
          if (cnt == LAST) begin
            done  <= 1'b1;
            cnt   <= 2'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Directed bench for mem_word_sequencer: a 4-byte and a 1-byte instance, each
// attached to its own 256x8 registered-read memory model.
module tb_mem_word_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, we;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic        done, busy, memread, memwrite;
  logic [7:0]  adr, writedata, memdata;

  logic        req1, we1;
  logic [7:0]  addr1, wdata1, rdata1;
  logic        done1, busy1, memread1, memwrite1;
  logic [7:0]  adr1, writedata1, memdata1;

  logic        pl_en, pl_sel;
  logic [7:0]  pl_addr, pl_data;

  logic [7:0]  mem4 [256];
  logic [7:0]  mem1 [256];

  int total = 0;
  int bad   = 0;

  mem_word_sequencer #(.NBYTES(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata)
  );

  mem_word_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .done(done1), .busy(busy1), .memread(memread1), .memwrite(memwrite1),
    .adr(adr1), .writedata(writedata1), .memdata(memdata1)
  );

  // Memory models; the bench preloads through the same write port.
  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem4[pl_addr] <= pl_data;
    else if (memwrite)    mem4[adr] <= writedata;
    memdata <= mem4[adr];
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel) mem1[pl_addr] <= pl_data;
    else if (memwrite1)  mem1[adr1] <= writedata1;
    memdata1 <= mem1[adr1];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [7:0] a, input logic [7:0] d);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_en = 1'b1;
    step;
    pl_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    req = 1'b1; we = 1'b0; addr = a;
    step;
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({memread, memwrite, done, busy, adr} !== {4'b1001, a + 8'(k)}) begin
        bad++;
        $display("[TB] FAIL %s_strobe k=%0d got=%b_%h want=1001_%h", nm, k,
                 {memread, memwrite, done, busy}, adr, a + 8'(k));
      end
      step;
    end
    total++;
    if ({memread, memwrite, done, busy, adr} !== {4'b0001, 8'h00}) begin
      bad++;
      $display("[TB] FAIL %s_tail got=%b_%h want=0001_00", nm, {memread, memwrite, done, busy}, adr);
    end
    step;
    total++;
    if ({done, busy, rdata} !== {2'b10, exp}) begin
      bad++;
      $display("[TB] FAIL %s_done got=%b_%h want=10_%h", nm, {done, busy}, rdata, exp);
    end
    step;
    total++;
    if ({done, busy, rdata} !== {2'b00, exp}) begin
      bad++;
      $display("[TB] FAIL %s_after got=%b_%h want=00_%h", nm, {done, busy}, rdata, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [31:0] prev,
                          input string nm);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    step;
    req = 1'b0; we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({memread, memwrite, done, busy, adr, writedata} !== {4'b0101, a + 8'(k), d[8*k +: 8]}) begin
        bad++;
        $display("[TB] FAIL %s_strobe k=%0d got=%b_%h_%h want=0101_%h_%h", nm, k,
                 {memread, memwrite, done, busy}, adr, writedata, a + 8'(k), d[8*k +: 8]);
      end
      step;
    end
    total++;
    if ({done, busy, memwrite, rdata} !== {3'b100, prev}) begin
      bad++;
      $display("[TB] FAIL %s_done got=%b_%h want=100_%h", nm, {done, busy, memwrite}, rdata, prev);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (mem4[a + 8'(k)] !== d[8*k +: 8]) begin
        bad++;
        $display("[TB] FAIL %s_mem k=%0d got=%h want=%h", nm, k, mem4[a + 8'(k)], d[8*k +: 8]);
      end
    end
    step;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_pulse got=%b want=0", nm, done);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, memread, memwrite, adr, writedata, rdata} !== 52'd0) begin
      bad++;
      $display("[TB] FAIL reset4 got=%b_%h_%h_%h want=all zero",
               {busy, done, memread, memwrite}, adr, writedata, rdata);
    end
    total++;
    if ({busy1, done1, memread1, memwrite1, adr1, writedata1, rdata1} !== 28'd0) begin
      bad++;
      $display("[TB] FAIL reset1 got=%b_%h_%h_%h want=all zero",
               {busy1, done1, memread1, memwrite1}, adr1, writedata1, rdata1);
    end
  endtask

  task automatic test_read;
    preload(1'b0, 8'h10, 8'h78);
    preload(1'b0, 8'h11, 8'h56);
    preload(1'b0, 8'h12, 8'h34);
    preload(1'b0, 8'h13, 8'h12);
    do_read(8'h10, 32'h12345678, "read");
  endtask

  task automatic test_write_readback;
    do_write(8'h20, 32'hDEADBEEF, 32'h12345678, "write");
    do_read(8'h20, 32'hDEADBEEF, "readback");
  endtask

  task automatic test_wrap;
    preload(1'b0, 8'hFE, 8'h01);
    preload(1'b0, 8'hFF, 8'h02);
    preload(1'b0, 8'h00, 8'h03);
    preload(1'b0, 8'h01, 8'h04);
    do_read(8'hFE, 32'h04030201, "wrap");
  endtask

  task automatic test_busy_ignore;
    int rd_cnt = 0, wr_cnt = 0, dn_cnt = 0, bad_adr = 0;
    req = 1'b1; we = 1'b0; addr = 8'h10;
    step;
    req = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (memread) rd_cnt++;
      if (memwrite) wr_cnt++;
      if (done) dn_cnt++;
      if (adr == 8'h30) bad_adr++;
      if (c == 1) begin req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 32'hCAFEF00D; end
      if (c == 2) begin req = 1'b0; we = 1'b0; end
      step;
    end
    total++;
    if ({rd_cnt, wr_cnt, dn_cnt, bad_adr} !== {32'd4, 32'd0, 32'd1, 32'd0}) begin
      bad++;
      $display("[TB] FAIL busy_ignore rd=%0d wr=%0d done=%0d adr30=%0d want 4 0 1 0",
               rd_cnt, wr_cnt, dn_cnt, bad_adr);
    end
    total++;
    if ({busy, rdata, mem4[8'h30]} !== {1'b0, 32'h12345678, mem4[8'h30]} || mem4[8'h30] === 8'h0D) begin
      bad++;
      $display("[TB] FAIL busy_final busy=%b rdata=%h mem30=%h want 0 12345678 not0D",
               busy, rdata, mem4[8'h30]);
    end
  endtask

  task automatic test_back_to_back;
    req = 1'b1; we = 1'b0; addr = 8'h10;
    step;
    addr = 8'h20;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({busy, done, adr} !== {2'b10, (k < 4) ? 8'h10 + 8'(k) : 8'h00}) begin
        bad++;
        $display("[TB] FAIL b2b_first k=%0d got=%b_%h", k, {busy, done}, adr);
      end
      step;
    end
    total++;
    if ({done, busy, rdata} !== {2'b10, 32'h12345678}) begin
      bad++;
      $display("[TB] FAIL b2b_done1 got=%b_%h want=10_12345678", {done, busy}, rdata);
    end
    step;
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({memread, busy, done, adr} !== {3'b110, 8'h20 + 8'(k)}) begin
        bad++;
        $display("[TB] FAIL b2b_second k=%0d got=%b_%h want=110_%h", k,
                 {memread, busy, done}, adr, 8'h20 + 8'(k));
      end
      step;
    end
    step;
    total++;
    if ({done, rdata} !== {1'b1, 32'hDEADBEEF}) begin
      bad++;
      $display("[TB] FAIL b2b_done2 got=%b_%h want=1_deadbeef", done, rdata);
    end
    step;
  endtask

  task automatic test_reset_midwrite;
    preload(1'b0, 8'h40, 8'h00);
    preload(1'b0, 8'h41, 8'h00);
    preload(1'b0, 8'h42, 8'hAA);
    preload(1'b0, 8'h43, 8'hBB);
    req = 1'b1; we = 1'b1; addr = 8'h40; wdata = 32'h11223344;
    step;
    req = 1'b0; we = 1'b0;
    step;
    total++;
    if ({memwrite, adr, writedata} !== {1'b1, 8'h41, 8'h33}) begin
      bad++;
      $display("[TB] FAIL rstwr_second got=%b_%h_%h want=1_41_33", memwrite, adr, writedata);
    end
    reset = 1'b1;
    step;
    total++;
    if ({busy, done, memread, memwrite, adr, writedata, rdata} !== 52'd0) begin
      bad++;
      $display("[TB] FAIL rstwr_outputs got=%b_%h_%h_%h want=all zero",
               {busy, done, memread, memwrite}, adr, writedata, rdata);
    end
    total++;
    if ({mem4[8'h40], mem4[8'h41], mem4[8'h42], mem4[8'h43]} !== 32'h4433AABB) begin
      bad++;
      $display("[TB] FAIL rstwr_mem got=%h%h%h%h want=4433aabb",
               mem4[8'h40], mem4[8'h41], mem4[8'h42], mem4[8'h43]);
    end
    reset = 1'b0;
    step;
    total++;
    if ({done, busy, memwrite} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rstwr_nodone got=%b want=000", {done, busy, memwrite});
    end
  endtask

  task automatic test_nbytes1;
    preload(1'b1, 8'h05, 8'hA5);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    step;
    req1 = 1'b0;
    total++;
    if ({memread1, busy1, done1, adr1} !== {3'b110, 8'h05}) begin
      bad++;
      $display("[TB] FAIL n1_read_strobe got=%b_%h want=110_05", {memread1, busy1, done1}, adr1);
    end
    step;
    total++;
    if ({memread1, busy1, done1} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL n1_read_tail got=%b want=010", {memread1, busy1, done1});
    end
    step;
    total++;
    if ({done1, busy1, rdata1} !== {2'b10, 8'hA5}) begin
      bad++;
      $display("[TB] FAIL n1_read_done got=%b_%h want=10_a5", {done1, busy1}, rdata1);
    end
    step;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h07; wdata1 = 8'h5C;
    step;
    req1 = 1'b0; we1 = 1'b0;
    total++;
    if ({memwrite1, done1, adr1, writedata1} !== {2'b10, 8'h07, 8'h5C}) begin
      bad++;
      $display("[TB] FAIL n1_write_strobe got=%b_%h_%h want=10_07_5c",
               {memwrite1, done1}, adr1, writedata1);
    end
    step;
    total++;
    if ({done1, busy1, rdata1, mem1[8'h07]} !== {2'b10, 8'hA5, 8'h5C}) begin
      bad++;
      $display("[TB] FAIL n1_write_done got=%b_%h_%h want=10_a5_5c",
               {done1, busy1}, rdata1, mem1[8'h07]);
    end
    step;
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    step;
    step;
    test_reset;
    reset = 1'b0;
    step;
    test_read;
    test_write_readback;
    test_wrap;
    test_busy_ignore;
    test_back_to_back;
    test_reset_midwrite;
    test_nbytes1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
